drift_request_controller: RTL and testbench

Sits directly upstream of the preemptive event generator and feeds its drift handshake (`drift_req`/`drift_ack`, direction, amount). Accepts single-cycle drift commands from user logic and nets them into a signed backlog, then issues bounded drift steps. Each step is issued only during the clock half-phase chosen by the user, read from the generator's unpausable clock state. Holds every request stable until the generator acknowledges it.

---
 rtl/clks_alot_p.sv | 17 +
 rtl/common_p.sv | 9 +
 rtl/drift_request_controller.sv | 163 ++++++++++++++++
 tb/tb_drift_request_controller.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clks_alot_p.sv
// Shared types for the clock generator family: drift counter width, drift
// direction encoding and the generator's unpausable clock state.
package clks_alot_p;

  localparam int DRIFT_COUNTER_WIDTH = 8;

  // DELAY lengthens the generated period, ADVANCE shortens it.
  typedef enum logic {
    DELAY   = 1'b0,
    ADVANCE = 1'b1
  } drift_direction_e;

  typedef struct packed {
    logic clk;
  } clock_state_s;

endpackage

// File: rtl/common_p.sv
// Common clock-domain bundle: one clock plus its synchronous active-low reset.
package common_p;

  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;

endpackage

// File: rtl/drift_request_controller.sv
// Nets single-cycle drift commands into a saturating signed backlog and feeds
// the generator bounded, phase-aligned drift requests over a req/ack handshake.
module drift_request_controller
  import clks_alot_p::*;
(
  input  common_p::clk_dom_s           sys_dom_i,
  input  logic                         drift_en_i,
  input  logic                         cmd_valid_i,
  input  drift_direction_e             cmd_direction_i,
  input  logic [DRIFT_COUNTER_WIDTH-1:0] cmd_amount_i,
  input  logic                         clear_i,
  input  logic [DRIFT_COUNTER_WIDTH-1:0] max_step_i,
  input  logic                         target_high_i,
  input  logic                         any_phase_i,
  input  clock_state_s                 clk_state_i,
  output logic                         drift_req_o,
  input  logic                         drift_ack_i,
  output drift_direction_e             drift_direction_o,
  output logic [DRIFT_COUNTER_WIDTH-1:0] drift_amount_o,
  output logic                         pending_o,
  output logic                         overflow_o
);

  localparam int DCW = DRIFT_COUNTER_WIDTH;
  localparam int AW  = DCW + 2;
  localparam int SW  = DCW + 3;

  localparam logic signed [SW-1:0] ACC_MAX = {2'b00, {(DCW + 1){1'b1}}};
  localparam logic signed [SW-1:0] ACC_MIN = -ACC_MAX;

  // Handshake: drift_req_o rises with direction/amount already valid and all
  // three stay frozen until a cycle with drift_req_o & drift_ack_i; the
  // request then drops on the next edge. drift_ack_i is ignored while idle.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PHASE = 2'd1,
    REQUEST    = 2'd2
  } state_e;

  logic clk;
  logic rst_n;

  state_e                 state;
  logic signed [AW-1:0]   acc;
  logic                   clr_seen;

  logic                   ack_fire;
  logic                   sub_en;
  logic signed [SW-1:0]   issued;
  logic signed [SW-1:0]   cmd;
  logic signed [SW-1:0]   sum;
  logic signed [AW-1:0]   acc_next;
  logic                   clip;
  logic                   acc_nz;
  logic [AW-1:0]          acc_mag;
  logic [DCW-1:0]         clamp;
  logic [DCW-1:0]         step_amount;
  drift_direction_e       step_dir;
  logic                   phase_ok;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  assign pending_o = acc_nz | drift_req_o;

  always_comb begin
    ack_fire = drift_req_o & drift_ack_i;
    // A clear seen at any point of the outstanding request voids its subtraction.
    sub_en   = ack_fire & ~clear_i & ~clr_seen;

    issued = (drift_direction_o == ADVANCE) ? SW'(drift_amount_o) : -SW'(drift_amount_o);
    cmd    = (cmd_direction_i == ADVANCE) ? SW'(cmd_amount_i) : -SW'(cmd_amount_i);

    sum = SW'(acc);
    if (sub_en) begin
      sum = sum - issued;
    end
    if (cmd_valid_i) begin
      sum = sum + cmd;
    end

    clip     = 1'b0;
    acc_next = sum[AW-1:0];
    if (sum > ACC_MAX) begin
      clip     = 1'b1;
      acc_next = ACC_MAX[AW-1:0];
    end else if (sum < ACC_MIN) begin
      clip     = 1'b1;
      acc_next = ACC_MIN[AW-1:0];
    end

    acc_nz   = (acc != '0);
    acc_mag  = acc[AW-1] ? AW'(-acc) : AW'(acc);
    clamp    = (max_step_i == '0) ? {DCW{1'b1}} : max_step_i;
    step_amount = (acc_mag > AW'(clamp)) ? clamp : acc_mag[DCW-1:0];
    step_dir = acc[AW-1] ? DELAY : ADVANCE;
    phase_ok = any_phase_i | (clk_state_i.clk == target_high_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      acc               <= '0;
      clr_seen          <= 1'b0;
      overflow_o        <= 1'b0;
      drift_req_o       <= 1'b0;
      drift_direction_o <= DELAY;
      drift_amount_o    <= '0;
    end else begin
      if (clear_i) begin
        acc        <= '0;
        overflow_o <= 1'b0;
      end else begin
        acc <= acc_next;
        if (clip) begin
          overflow_o <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (drift_en_i && acc_nz && !clear_i) begin
            if (phase_ok) begin
              state             <= REQUEST;
              drift_req_o       <= 1'b1;
              drift_direction_o <= step_dir;
              drift_amount_o    <= step_amount;
              clr_seen          <= 1'b0;
            end else begin
              state <= WAIT_PHASE;
            end
          end
        end
        WAIT_PHASE: begin
          if (!drift_en_i || !acc_nz || clear_i) begin
            state <= IDLE;
          end else if (phase_ok) begin
            state             <= REQUEST;
            drift_req_o       <= 1'b1;
            drift_direction_o <= step_dir;
            drift_amount_o    <= step_amount;
            clr_seen          <= 1'b0;
          end
        end
        REQUEST: begin
          // Never withdrawn: only the ack ends a request.
          if (ack_fire) begin
            state       <= IDLE;
            drift_req_o <= 1'b0;
            clr_seen    <= 1'b0;
          end else if (clear_i) begin
            clr_seen <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          drift_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drift_request_controller.sv
// Directed bench for drift_request_controller: expected requests are queued as
// commands are driven and compared when the DUT raises drift_req_o.
module tb_drift_request_controller;
  import clks_alot_p::*;

  localparam int DCW = DRIFT_COUNTER_WIDTH;

  logic               clk;
  logic               rst_n;
  logic               ph_clk;
  common_p::clk_dom_s sys_dom;
  clock_state_s       clk_state;

  logic               drift_en;
  logic               cmd_valid;
  drift_direction_e   cmd_dir;
  logic [DCW-1:0]     cmd_amount;
  logic               clear;
  logic [DCW-1:0]     max_step;
  logic               target_high;
  logic               any_phase;
  logic               drift_req;
  logic               drift_ack;
  drift_direction_e   drift_dir;
  logic [DCW-1:0]     drift_amount;
  logic               pending;
  logic               overflow;

  int checks = 0;
  int errors = 0;
  logic [DCW:0] exp_q[$];

  assign sys_dom   = '{clk: clk, rst_n: rst_n};
  assign clk_state = '{clk: ph_clk};

  drift_request_controller dut (
    .sys_dom_i         (sys_dom),
    .drift_en_i        (drift_en),
    .cmd_valid_i       (cmd_valid),
    .cmd_direction_i   (cmd_dir),
    .cmd_amount_i      (cmd_amount),
    .clear_i           (clear),
    .max_step_i        (max_step),
    .target_high_i     (target_high),
    .any_phase_i       (any_phase),
    .clk_state_i       (clk_state),
    .drift_req_o       (drift_req),
    .drift_ack_i       (drift_ack),
    .drift_direction_o (drift_dir),
    .drift_amount_o    (drift_amount),
    .pending_o         (pending),
    .overflow_o        (overflow)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input drift_direction_e dir, input logic [DCW-1:0] amt);
    exp_q.push_back({dir, amt});
  endtask

  task automatic drive_cmd(input drift_direction_e dir, input logic [DCW-1:0] amt);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_amount = amt;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic compare_req(input string tag);
    logic [DCW:0] e;
    check({tag, "_req"}, 32'(drift_req), 32'd1);
    check({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_dir_amt"}, 32'({drift_dir, drift_amount}), 32'(e));
    end
  endtask

  task automatic wait_req(input string tag, input int max_cycles);
    int n = 0;
    while (!drift_req && n < max_cycles) begin
      tick();
      n++;
    end
    compare_req(tag);
  endtask

  task automatic ack_req(input string tag);
    drift_ack = 1'b1;
    tick();
    drift_ack = 1'b0;
    check({tag, "_req_low_after_ack"}, 32'(drift_req), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 32'(drift_req), 32'd0);
    check({tag, "_dir"}, 32'(drift_dir), 32'(DELAY));
    check({tag, "_amount"}, 32'(drift_amount), 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Directed sequence
  initial begin
    rst_n       = 1'b0;
    ph_clk      = 1'b0;
    drift_en    = 1'b1;
    cmd_valid   = 1'b0;
    cmd_dir     = DELAY;
    cmd_amount  = '0;
    clear       = 1'b0;
    max_step    = '0;
    target_high = 1'b0;
    any_phase   = 1'b1;
    drift_ack   = 1'b0;

    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Stray ack while idle has no effect
    drift_ack = 1'b1;
    tick(2);
    drift_ack = 1'b0;
    check("stray_ack_req", 32'(drift_req), 32'd0);
    check("stray_ack_pending", 32'(pending), 32'd0);

    // Basic handshake: cmd at cycle 0, req at cycle 2, ack at 4, low at 5
    push_exp(ADVANCE, 8'd5);
    drive_cmd(ADVANCE, 8'd5);
    check("basic_c1_req", 32'(drift_req), 32'd0);
    check("basic_c1_pending", 32'(pending), 32'd1);
    tick();
    compare_req("basic_c2");
    tick();
    check("basic_c3_hold", 32'(drift_req), 32'd1);
    tick();
    ack_req("basic");
    check("basic_pending_done", 32'(pending), 32'd0);

    // Clamp: DELAY 7 with max_step 3 gives 3, 3, 1
    max_step = 8'd3;
    push_exp(DELAY, 8'd3);
    push_exp(DELAY, 8'd3);
    push_exp(DELAY, 8'd1);
    drive_cmd(DELAY, 8'd7);
    for (int i = 0; i < 3; i++) begin
      wait_req($sformatf("clamp%0d", i), 20);
      tick();
      check($sformatf("clamp%0d_hold", i), 32'(drift_req), 32'd1);
      ack_req($sformatf("clamp%0d", i));
    end
    check("clamp_pending_done", 32'(pending), 32'd0);
    max_step = '0;

    // Phase gating: wait for clk_state.clk high
    any_phase   = 1'b0;
    target_high = 1'b1;
    push_exp(ADVANCE, 8'd9);
    drive_cmd(ADVANCE, 8'd9);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("phase_hold%0d", i), 32'(drift_req), 32'd0);
      tick();
    end
    check("phase_hold4", 32'(drift_req), 32'd0);
    ph_clk = 1'b1;
    tick();
    compare_req("phase_rise");
    ack_req("phase");
    ph_clk    = 1'b0;
    any_phase = 1'b1;
    target_high = 1'b0;

    // Command coinciding with the ack
    push_exp(ADVANCE, 8'd4);
    push_exp(ADVANCE, 8'd2);
    drive_cmd(ADVANCE, 8'd4);
    wait_req("simul_first", 10);
    drift_ack  = 1'b1;
    cmd_valid  = 1'b1;
    cmd_dir    = ADVANCE;
    cmd_amount = 8'd2;
    tick();
    drift_ack  = 1'b0;
    cmd_valid  = 1'b0;
    check("simul_req_low", 32'(drift_req), 32'd0);
    check("simul_pending", 32'(pending), 32'd1);
    wait_req("simul_second", 10);
    ack_req("simul_second");
    check("simul_pending_done", 32'(pending), 32'd0);

    // Saturation, then clear while requesting
    push_exp(DELAY, 8'd255);
    for (int i = 0; i < 5; i++) begin
      cmd_valid  = 1'b1;
      cmd_dir    = DELAY;
      cmd_amount = 8'd255;
      tick();
    end
    cmd_valid = 1'b0;
    compare_req("sat");
    check("sat_overflow", 32'(overflow), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_req_held", 32'(drift_req), 32'd1);
    check("clear_overflow", 32'(overflow), 32'd0);
    check("clear_pending_req", 32'(pending), 32'd1);
    tick();
    check("clear_req_held2", 32'(drift_req), 32'd1);
    ack_req("clear");
    check("clear_pending_done", 32'(pending), 32'd0);
    tick(6);
    check("clear_no_further_req", 32'(drift_req), 32'd0);
    check("clear_no_backlog", 32'(pending), 32'd0);

    // Enable gating; disabling does not retract an issued request
    drift_en = 1'b0;
    push_exp(ADVANCE, 8'd1);
    drive_cmd(ADVANCE, 8'd1);
    tick(4);
    check("en_off_req", 32'(drift_req), 32'd0);
    check("en_off_pending", 32'(pending), 32'd1);
    drift_en = 1'b1;
    wait_req("en_on", 5);
    drift_en = 1'b0;
    tick();
    check("en_off_hold", 32'(drift_req), 32'd1);
    ack_req("en");
    drift_en = 1'b1;
    check("en_pending_done", 32'(pending), 32'd0);

    // Reset during an outstanding request
    push_exp(ADVANCE, 8'd3);
    drive_cmd(ADVANCE, 8'd3);
    wait_req("rst_mid", 10);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("rst_mid");
    rst_n = 1'b1;
    tick(5);
    check("rst_no_req_after", 32'(drift_req), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
